// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared encodings and instruction field layout for the CIM sequencer
package cim_pkg;

  // Default datapath geometry
  localparam int DEF_INST_W = 16;
  localparam int DEF_SLOTS  = 2;

  // Instruction field layout, LSB upward: wb_en, slide_en, core_a, sel_top, wb_a, act_rd_a
  localparam int WB_EN_BIT = 0;
  localparam int SLIDE_BIT = 1;
  localparam int CORE_BIT  = 2;
  localparam int SEL_BIT   = 3;
  localparam int WB_A_LSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // act_rd_a sits directly above the write-back address field
  function automatic int act_lsb(input int wb_a_w);
    return WB_A_LSB + wb_a_w;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - DEPTH x WIDTH shift register with valid tag and stall hold
module pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic             vld_q  [DEPTH];

  // Shift data and valid together; a stall freezes every stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else if (!stall) begin
      data_q[0] <= in_data;
      vld_q[0]  <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];

endmodule

// File: rtl/pip_sequencer.sv
// rtl/pip_sequencer.sv - CIM instruction sequencer with start/done, looping, stall and stage valids
module pip_sequencer
  import cim_pkg::*;
#(
  parameter int INST_W     = DEF_INST_W,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int IMEM_DEPTH = 32,
  parameter int ACT_A_W    = 5,
  parameter int WB_A_W     = 7,
  parameter int WB_DELAY   = 3,
  parameter int CORE_DELAY = 1,
  parameter int LOOP_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(IMEM_DEPTH*SLOTS):0] prog_len,
  input  logic [LOOP_W-1:0]                 loop_cnt,
  input  logic                              stall,
  output logic [$clog2(IMEM_DEPTH)-1:0]     imem_addr,
  input  logic [INST_W*SLOTS-1:0]           imem_q,
  output logic [ACT_A_W-1:0]                act_rd_a,
  output logic                              sel_top,
  output logic                              act_rd_v,
  output logic                              core_a,
  output logic                              slide_en,
  output logic [WB_A_W-1:0]                 wb_a,
  output logic                              wb_sel_top,
  output logic                              wb_en,
  output logic                              busy,
  output logic                              done
);

  localparam int PC_W     = $clog2(IMEM_DEPTH*SLOTS);
  localparam int LEN_W    = PC_W + 1;
  localparam int IA_W     = $clog2(IMEM_DEPTH);
  localparam int SLOT_SH  = $clog2(SLOTS);
  localparam int SLOT_W   = (SLOTS > 1) ? SLOT_SH : 1;
  localparam int ACT_LSB  = act_lsb(WB_A_W);
  localparam int DR_W     = $clog2(WB_DELAY + 1) + 1;
  localparam int PASS_W   = LOOP_W + 1;
  localparam int WB_GRP_W = WB_A_W + 2;

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [LOOP_W-1:0]   pass_q, pass_d;
  logic [DR_W-1:0]     drain_q, drain_d;
  logic [LOOP_W-1:0]   loop_eff;
  logic [PASS_W-1:0]   pass_next;
  logic                more_passes;
  logic                last_pc;

  assign loop_eff    = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
  assign pass_next   = {1'b0, pass_q} + PASS_W'(1);
  assign more_passes = pass_next < {1'b0, loop_eff};
  assign last_pc     = ({1'b0, pc_q} == (prog_len - LEN_W'(1)));

  // FSM and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      pass_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pass_q  <= pass_d;
      drain_q <= drain_d;
    end
  end

  // Next-state: issue one pc per unstalled RUN cycle, wrap passes without a bubble, then drain
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          pass_d  = '0;
          drain_d = '0;
          state_d = (prog_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (last_pc) begin
            if (more_passes) begin
              pc_d   = '0;
              pass_d = pass_next[LOOP_W-1:0];
            end else begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (drain_q == DR_W'(WB_DELAY)) begin
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q + DR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = IA_W'(pc_q >> SLOT_SH);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  logic              iss_v_q;
  logic [SLOT_W-1:0] iss_slot_q;

  // Issue stage: tag the SRAM read in flight with its slot and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q    <= 1'b0;
      iss_slot_q <= '0;
    end else if (!stall) begin
      iss_v_q    <= (state_q == ST_RUN);
      iss_slot_q <= SLOT_W'(pc_q % PC_W'(SLOTS));
    end
  end

  // The SRAM keeps reading the frozen pc during a stall, which can be a
  // different word from the one the issue stage is waiting for, so the
  // word that arrived on the first stalled cycle is parked here.
  logic [INST_W*SLOTS-1:0] hold_q;
  logic                    hold_v_q;

  // Park the in-flight SRAM word for the duration of a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (stall) begin
      if (!hold_v_q) hold_q <= imem_q;
      hold_v_q <= 1'b1;
    end else begin
      hold_v_q <= 1'b0;
    end
  end

  logic [INST_W*SLOTS-1:0] word_sel;
  logic [INST_W-1:0]       inst_cur;
  logic [INST_W-1:0]       ir_q;
  logic                    ir_v_q;

  assign word_sel = hold_v_q ? hold_q : imem_q;
  assign inst_cur = word_sel[int'(iss_slot_q)*INST_W +: INST_W];

  // Instruction register (LD stage); bubbles keep the previous contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= '0;
      ir_v_q <= 1'b0;
    end else if (!stall) begin
      ir_v_q <= iss_v_q;
      if (iss_v_q) ir_q <= inst_cur;
    end
  end

  assign act_rd_a = ir_q[ACT_LSB +: ACT_A_W];
  assign sel_top  = ir_q[SEL_BIT];
  assign act_rd_v = ir_v_q;

  logic [1:0]          cim_data;
  logic                cim_v;
  logic [WB_GRP_W-1:0] wb_data;
  logic                wb_v;

  pipe_delay #(.DEPTH(CORE_DELAY), .WIDTH(2)) u_cim_delay (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (ir_v_q),
    .in_data   ({ir_q[CORE_BIT], ir_q[SLIDE_BIT]}),
    .out_valid (cim_v),
    .out_data  (cim_data)
  );

  pipe_delay #(.DEPTH(WB_DELAY), .WIDTH(WB_GRP_W)) u_wb_delay (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (ir_v_q),
    .in_data   ({ir_q[WB_A_LSB +: WB_A_W], ir_q[SEL_BIT], ir_q[WB_EN_BIT]}),
    .out_valid (wb_v),
    .out_data  (wb_data)
  );

  assign core_a     = cim_data[1];
  assign slide_en   = cim_data[0] & cim_v;
  assign wb_a       = wb_data[WB_GRP_W-1:2];
  assign wb_sel_top = wb_data[1];
  // A stalled WB stage is shown again next cycle, so it must not write twice
  assign wb_en      = wb_data[0] & wb_v & ~stall;

endmodule

// File: tb/tb_pip_sequencer.sv
// tb/tb_pip_sequencer.sv - self-checking bench for pip_sequencer
module tb_pip_sequencer;

  localparam int INST_W = 16, SLOTS = 2, IMEM_DEPTH = 32, ACT_A_W = 5, WB_A_W = 7;
  localparam int WB_DELAY = 3, CORE_DELAY = 1, LOOP_W = 8;
  localparam int LEN_W = $clog2(IMEM_DEPTH*SLOTS) + 1;
  localparam int IA_W  = $clog2(IMEM_DEPTH);

  logic clk = 1'b0;
  logic rst, start, stall;
  logic [LEN_W-1:0] prog_len;
  logic [LOOP_W-1:0] loop_cnt;
  logic [IA_W-1:0] imem_addr;
  logic [INST_W*SLOTS-1:0] imem_q;
  logic [ACT_A_W-1:0] act_rd_a;
  logic sel_top, act_rd_v, core_a, slide_en, wb_sel_top, wb_en, busy, done;
  logic [WB_A_W-1:0] wb_a;

  logic [INST_W*SLOTS-1:0] mem [IMEM_DEPTH];

  typedef struct { int eff; int a; int b; } ev_t;
  ev_t act_q[$], slide_q[$], wb_q[$];
  int obs_ia[$], obs_eff[$], obs_busy[$];
  int r_done_t, r_done_cnt;
  int vectors = 0, miscompares = 0;

  pip_sequencer #(
    .INST_W(INST_W), .SLOTS(SLOTS), .IMEM_DEPTH(IMEM_DEPTH), .ACT_A_W(ACT_A_W),
    .WB_A_W(WB_A_W), .WB_DELAY(WB_DELAY), .CORE_DELAY(CORE_DELAY), .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .loop_cnt(loop_cnt),
    .stall(stall), .imem_addr(imem_addr), .imem_q(imem_q), .act_rd_a(act_rd_a),
    .sel_top(sel_top), .act_rd_v(act_rd_v), .core_a(core_a), .slide_en(slide_en),
    .wb_a(wb_a), .wb_sel_top(wb_sel_top), .wb_en(wb_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction SRAM, one cycle latency
  always @(posedge clk) imem_q <= mem[imem_addr];

  function automatic logic [INST_W-1:0] inst_at(input int pc);
    logic [INST_W*SLOTS-1:0] w;
    w = mem[pc / SLOTS];
    return w[(pc % SLOTS)*INST_W +: INST_W];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom();
  endtask

  // Runs one program; an unstalled instruction k reaches LD at effective cycle k+2,
  // CIM at k+2+CORE_DELAY, WB at k+2+WB_DELAY; done follows 1+WB_DELAY drain cycles.
  task automatic run_scenario(input string name, input int p, input int l,
                              input int st_at, input int st_len, input bit restart);
    int n, exp_done_t, eff, bad, first_bad;
    logic [INST_W-1:0] ins;
    ev_t e;
    ev_t exp_act[$], exp_slide[$], exp_wb[$];
    act_q.delete(); slide_q.delete(); wb_q.delete();
    obs_ia.delete(); obs_eff.delete(); obs_busy.delete();
    n = p * ((l == 0) ? 1 : l);
    exp_done_t = (p == 0) ? 0 : n + 1 + WB_DELAY + st_len;
    for (int k = 0; k < n; k++) begin
      ins = inst_at(k % p);
      e.eff = k + 2; e.a = int'(ins[15:11]); e.b = int'(ins[3]);
      exp_act.push_back(e);
      if (ins[1]) begin e.eff = k + 2 + CORE_DELAY; e.a = int'(ins[2]); e.b = 0; exp_slide.push_back(e); end
      if (ins[0]) begin e.eff = k + 2 + WB_DELAY; e.a = int'(ins[10:4]); e.b = int'(ins[3]); exp_wb.push_back(e); end
    end
    @(negedge clk);
    prog_len = LEN_W'(p); loop_cnt = LOOP_W'(l); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    eff = 0; r_done_cnt = 0; r_done_t = -1;
    for (int t = 0; t < 150; t++) begin
      stall = (t >= st_at) && (t < st_at + st_len);
      start = restart && (t == 2);
      #1;
      obs_ia.push_back(int'(imem_addr)); obs_eff.push_back(eff); obs_busy.push_back(int'(busy));
      if (done) begin r_done_cnt++; if (r_done_t < 0) r_done_t = t; end
      if (wb_en) begin e.eff = eff; e.a = int'(wb_a); e.b = int'(wb_sel_top); wb_q.push_back(e); end
      if (!stall) begin
        if (act_rd_v) begin e.eff = eff; e.a = int'(act_rd_a); e.b = int'(sel_top); act_q.push_back(e); end
        if (slide_en) begin e.eff = eff; e.a = int'(core_a); e.b = 0; slide_q.push_back(e); end
        eff++;
      end
      if (r_done_t >= 0 && t >= r_done_t + 3) break;
      @(negedge clk);
    end
    stall = 1'b0; start = 1'b0;

    vectors++;
    if (r_done_t !== exp_done_t || r_done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s done: got cycle %0d count %0d, want cycle %0d count 1", name, r_done_t, r_done_cnt, exp_done_t);
    end
    bad = 0; first_bad = -1;
    foreach (obs_busy[t]) if (obs_busy[t] !== int'(t <= exp_done_t)) begin bad++; if (first_bad < 0) first_bad = t; end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s busy: %0d wrong cycles, first at %0d, want high through cycle %0d", name, bad, first_bad, exp_done_t);
    end
    bad = 0; first_bad = -1;
    foreach (obs_ia[t]) if (p != 0 && obs_eff[t] < n && obs_ia[t] !== (obs_eff[t] % p) / SLOTS) begin
      bad++; if (first_bad < 0) first_bad = t;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s imem_addr: %0d wrong cycles, first at %0d got %0d", name, bad, first_bad, obs_ia[first_bad]);
    end
    vectors++;
    if (act_q.size() !== exp_act.size() || slide_q.size() !== exp_slide.size() || wb_q.size() !== exp_wb.size()) begin
      miscompares++;
      $display("FAIL %s counts: got act=%0d slide=%0d wb=%0d, want act=%0d slide=%0d wb=%0d", name,
               act_q.size(), slide_q.size(), wb_q.size(), exp_act.size(), exp_slide.size(), exp_wb.size());
    end
    for (int k = 0; k < exp_act.size() && k < act_q.size(); k++) begin
      vectors++;
      if (act_q[k].eff !== exp_act[k].eff || act_q[k].a !== exp_act[k].a || act_q[k].b !== exp_act[k].b) begin
        miscompares++;
        $display("FAIL %s act[%0d]: got eff=%0d a=%0d sel=%0d, want eff=%0d a=%0d sel=%0d", name, k,
                 act_q[k].eff, act_q[k].a, act_q[k].b, exp_act[k].eff, exp_act[k].a, exp_act[k].b);
      end
    end
    for (int k = 0; k < exp_slide.size() && k < slide_q.size(); k++) begin
      vectors++;
      if (slide_q[k].eff !== exp_slide[k].eff || slide_q[k].a !== exp_slide[k].a) begin
        miscompares++;
        $display("FAIL %s slide[%0d]: got eff=%0d core=%0d, want eff=%0d core=%0d", name, k,
                 slide_q[k].eff, slide_q[k].a, exp_slide[k].eff, exp_slide[k].a);
      end
    end
    for (int k = 0; k < exp_wb.size() && k < wb_q.size(); k++) begin
      vectors++;
      if (wb_q[k].eff !== exp_wb[k].eff || wb_q[k].a !== exp_wb[k].a || wb_q[k].b !== exp_wb[k].b) begin
        miscompares++;
        $display("FAIL %s wb[%0d]: got eff=%0d a=%0d sel=%0d, want eff=%0d a=%0d sel=%0d", name, k,
                 wb_q[k].eff, wb_q[k].a, wb_q[k].b, exp_wb[k].eff, exp_wb[k].a, exp_wb[k].b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; prog_len = '0; loop_cnt = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, act_rd_v, slide_en, wb_en} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got busy/done/act_v/slide/wb=%b, want 00000", {busy, done, act_rd_v, slide_en, wb_en});
    end
    vectors++;
    if ({imem_addr, act_rd_a, wb_a, sel_top, core_a, wb_sel_top} !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got imem=%0d act=%0d wb_a=%0d, want 0", imem_addr, act_rd_a, wb_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [INST_W-1:0] ins;
    fill_random();
    for (int k = 0; k < 4; k++) begin
      ins = $urandom();
      ins[15:11] = 5'(k + 1); ins[0] = 1'b1;
      mem[k / SLOTS][(k % SLOTS)*INST_W +: INST_W] = ins;
    end
    run_scenario("basic", 4, 1, 999, 0, 1'b0);
    for (int k = 0; k < 4 && k < act_q.size(); k++) begin
      vectors++;
      if (act_q[k].a !== k + 1) begin
        miscompares++;
        $display("FAIL basic_seq[%0d]: got act_rd_a=%0d, want %0d", k, act_q[k].a, k + 1);
      end
    end
    vectors++;
    if (wb_q.size() !== 4 || (wb_q.size() > 0 && wb_q[0].eff !== 5)) begin
      miscompares++;
      $display("FAIL basic_wb: got %0d writes, want 4 starting at cycle 5", wb_q.size());
    end
  endtask

  task automatic test_loop_wrap();
    int exp_ia[6];
    exp_ia = '{0, 0, 1, 0, 0, 1};
    fill_random();
    run_scenario("loop_wrap", 3, 2, 999, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      vectors++;
      if (obs_ia[t] !== exp_ia[t]) begin
        miscompares++;
        $display("FAIL wrap_addr[%0d]: got imem_addr=%0d, want %0d", t, obs_ia[t], exp_ia[t]);
      end
    end
  endtask

  task automatic test_stall();
    fill_random();
    run_scenario("stall", 6, 1, 4, 3, 1'b0);
    vectors++;
    if (r_done_t !== 6 + 1 + WB_DELAY + 3) begin
      miscompares++;
      $display("FAIL stall_done: got cycle %0d, want %0d", r_done_t, 6 + 1 + WB_DELAY + 3);
    end
  endtask

  task automatic test_zero_len();
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = '1;
    run_scenario("zero_len", 0, 1, 999, 0, 1'b0);
  endtask

  task automatic test_ignored_start();
    fill_random();
    run_scenario("busy_start", 5, 1, 999, 0, 1'b1);
  endtask

  task automatic test_random();
    int p, l, n;
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(1, 12);
      l = $urandom_range(0, 3);
      n = p * ((l == 0) ? 1 : l);
      fill_random();
      run_scenario("random", p, l, $urandom_range(0, n - 1), $urandom_range(0, 4), 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = '1;
    @(negedge clk);
    prog_len = LEN_W'(10); loop_cnt = LOOP_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, wb_en, done, act_rd_v} !== 4'b0 || imem_addr !== '0) begin
      miscompares++;
      $display("FAIL midrst_now: got busy/wb/done/act_v=%b imem=%0d, want 0000 0", {busy, wb_en, done, act_rd_v}, imem_addr);
    end
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy || done || wb_en || act_rd_v) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL midrst_after: got %0d cycles with activity, want 0", bad);
    end
  endtask

  initial begin
    fill_random();
    test_reset();
    test_basic();
    test_loop_wrap();
    test_stall();
    test_zero_len();
    test_ignored_start();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
